// File: rtl/rotf_pkg.sv
// rotf_pkg: shared types and constants for rot_amount_finder.
//   state_t   : FSM states (IDLE, SEARCH, DONE)
//   DIR_LEFT / DIR_RIGHT : encoding of the rotate direction bit
//   DEF_WIDTH : default data word width
package rotf_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rotf_step1.sv
// rotf_step1: combinational rotate-by-one of a WIDTH-bit word.
//   din  : word to rotate
//   dir  : DIR_LEFT (0) or DIR_RIGHT (1)
//   dout : din rotated by one position in direction dir
module rotf_step1
  import rotf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    if (dir == DIR_LEFT) dout = {din[WIDTH-2:0], din[WIDTH-1]};
    else                 dout = {din[0], din[WIDTH-1:1]};
  end

endmodule

// File: rtl/rot_amount_finder.sv
// rot_amount_finder: recovers the smallest rotate amount mapping cmd_src to
// cmd_tgt in direction cmd_dir, trying one candidate rotation per cycle.
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_src/cmd_tgt/cmd_dir : operands, latched on acceptance
//   res_valid/res_ready   : result handshake, result held until accepted
//   res_found/res_amount  : match flag and smallest amount (0 if none)
//   res_mask              : (ROTF_MATCH_MASK_EN only) bit k set iff rotate by k matches
//   busy                  : high in SEARCH or DONE, usable as clock-gate enable
// Build option: define ROTF_MATCH_MASK_EN to add res_mask and always scan all
// WIDTH rotations instead of stopping at the first match.
module rot_amount_finder
  import rotf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_src,
  input  logic [WIDTH-1:0] cmd_tgt,
  input  logic             cmd_dir,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_found,
  output logic [CNT_W-1:0] res_amount,
`ifdef ROTF_MATCH_MASK_EN
  output logic [WIDTH-1:0] res_mask,
`endif
  output logic             busy
);

  state_t             state;
  logic [WIDTH-1:0]   cand, tgt, cand_rot;
  logic               dir;
  logic [CNT_W-1:0]   count;
  logic               match, last;

  rotf_step1 #(.WIDTH(WIDTH)) u_step (.din(cand), .dir(dir), .dout(cand_rot));

  assign match = (cand == tgt);
  assign last  = (count == CNT_W'(WIDTH-1));

`ifdef ROTF_MATCH_MASK_EN
  logic [WIDTH-1:0] mask_q, mask_nxt;
  logic [CNT_W-1:0] low_amt;

  assign mask_nxt = mask_q | ({{(WIDTH-1){1'b0}}, match} << count);
  assign res_mask = mask_q;

  // lowest set bit wins: scan from the top so the last hit is the smallest
  always_comb begin
    low_amt = '0;
    for (int i = WIDTH-1; i >= 0; i--)
      if (mask_nxt[i]) low_amt = CNT_W'(i);
  end
`endif

  // The decision is made in SEARCH; res_valid is raised one cycle after DONE
  // is entered so the result registers are settled before they are offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      res_valid  <= 1'b0;
      res_found  <= 1'b0;
      res_amount <= '0;
      busy       <= 1'b0;
      cand       <= '0;
      tgt        <= '0;
      dir        <= 1'b0;
      count      <= '0;
`ifdef ROTF_MATCH_MASK_EN
      mask_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cand       <= cmd_src;
            tgt        <= cmd_tgt;
            dir        <= cmd_dir;
            count      <= '0;
            res_found  <= 1'b0;
            res_amount <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= SEARCH;
`ifdef ROTF_MATCH_MASK_EN
            mask_q     <= '0;
`endif
          end
        end
        SEARCH: begin
`ifdef ROTF_MATCH_MASK_EN
          mask_q <= mask_nxt;
          if (last) begin
            res_found  <= |mask_nxt;
            res_amount <= low_amt;
            state      <= DONE;
          end else begin
            cand  <= cand_rot;
            count <= count + 1'b1;
          end
`else
          if (match) begin
            res_found  <= 1'b1;
            res_amount <= count;
            state      <= DONE;
          end else if (last) begin
            res_found  <= 1'b0;
            res_amount <= '0;
            state      <= DONE;
          end else begin
            cand  <= cand_rot;
            count <= count + 1'b1;
          end
`endif
        end
        DONE: begin
          if (!res_valid) begin
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rot_amount_finder.sv
module tb_rot_amount_finder;
  import rotf_pkg::*;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_dir;
  logic [W-1:0]  cmd_src, cmd_tgt;
  logic          res_valid, res_ready, res_found, busy;
  logic [CW-1:0] res_amount;
`ifdef ROTF_MATCH_MASK_EN
  logic [W-1:0]  res_mask;
  localparam bit MASK_MODE = 1'b1;
`else
  localparam bit MASK_MODE = 1'b0;
`endif

  rot_amount_finder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_tgt(cmd_tgt), .cmd_dir(cmd_dir),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_found(res_found), .res_amount(res_amount),
`ifdef ROTF_MATCH_MASK_EN
    .res_mask(res_mask),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         found;
    logic [3:0]   amt;
    logic [15:0]  mask;
    int           lat;
    int           t_acc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compare each newly presented result against the scoreboard
  initial begin
    logic rv_q;
    exp_t e;
    rv_q = 1'b0;
    forever begin
      @(negedge clk);
      if (res_valid && !rv_q) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 32'(res_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("res_found",  32'(res_found),  32'(e.found));
          chk("res_amount", 32'(res_amount), 32'(e.amt));
          chk("latency",    32'(cyc - e.t_acc), 32'(e.lat));
`ifdef ROTF_MATCH_MASK_EN
          chk("res_mask",   32'(res_mask),   32'(e.mask));
`endif
        end
      end
      rv_q = res_valid;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // issue one command; push its expected result when push is set
  task automatic send(input logic [15:0] s, input logic [15:0] t, input logic d,
                      input logic f, input logic [3:0] a, input logic [15:0] m,
                      input bit push);
    exp_t e;
    wait_ready();
    cmd_src = s; cmd_tgt = t; cmd_dir = d; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    e.found = f; e.amt = a; e.mask = m; e.t_acc = cyc;
    e.lat   = (MASK_MODE || !f) ? W + 1 : 2 + int'(a);
    if (push) sbq.push_back(e);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_tgt = '0; cmd_dir = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {27'd0, cmd_ready, res_valid, res_found, busy, |res_amount}, 32'b10000);
    rst = 1'b0;
    @(negedge clk);

    send(16'h8001, 16'h0003, DIR_LEFT,  1'b1, 4'd1,  16'h0002, 1);
    send(16'h0001, 16'h8000, DIR_RIGHT, 1'b1, 4'd1,  16'h0002, 1);
    send(16'h0001, 16'h8000, DIR_LEFT,  1'b1, 4'd15, 16'h8000, 1);
    send(16'h1234, 16'h1234, DIR_LEFT,  1'b1, 4'd0,  16'h0001, 1);
    send(16'hAAAA, 16'h5555, DIR_LEFT,  1'b1, 4'd1,  16'hAAAA, 1);
    send(16'hFFFF, 16'hFFFF, DIR_RIGHT, 1'b1, 4'd0,  16'hFFFF, 1);

    // no-match; a second command offered mid-search must be ignored
    send(16'h0003, 16'h0005, DIR_LEFT,  1'b0, 4'd0,  16'h0000, 1);
    cmd_src = 16'h1234; cmd_tgt = 16'h1234; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cmd_ready_low_search", {30'd0, cmd_ready, busy}, 32'b01);
    end
    cmd_valid = 1'b0;
    wait_ready();

    // backpressure: result held while res_ready is low
    res_ready = 1'b0;
    send(16'h00F0, 16'h0F00, DIR_RIGHT, 1'b1, 4'd12, 16'h1000, 1);
    begin
      int n;
      n = 0;
      while (!res_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("hold_res_valid_seen", 32'(res_valid), 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_stable", {22'd0, res_valid, busy, cmd_ready, res_found, 2'd0, res_amount},
          {22'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'd12});
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("release_idle", {29'd0, res_valid, busy, cmd_ready}, 32'b001);

    // reset in the middle of a search: nothing must come out of it
    send(16'h0003, 16'h0005, DIR_LEFT, 1'b0, 4'd0, 16'h0000, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midsearch_rst", {27'd0, cmd_ready, res_valid, res_found, busy, |res_amount}, 32'b10000);
`ifdef ROTF_MATCH_MASK_EN
    chk("midsearch_rst_mask", 32'(res_mask), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    send(16'h1234, 16'h2341, DIR_LEFT, 1'b1, 4'd4, 16'h0010, 1);
    wait_ready();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d reached without finishing", cyc);
    $fatal(1, "timeout");
  end

endmodule
